// File: rtl/matdet_pkg.sv
// Shared state encoding and step counts for the 2x2 det(A*B) sequencer.
package matdet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DET  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int MUL_STEPS = 8;
    localparam int DET_STEPS = 2;

endpackage

// File: rtl/matdet_mac.sv
// Signed W x W multiply with add/subtract into a 2W accumulator, wrapping.
// With MATDET_OVF_FLAG_EN defined, also reports signed overflow of the add/sub.
module matdet_mac #(
    parameter int W = 7
) (
    input  logic signed [W-1:0]   i_a,
    input  logic signed [W-1:0]   i_b,
    input  logic signed [2*W-1:0] i_acc,
    input  logic                  i_sub,
`ifdef MATDET_OVF_FLAG_EN
    output logic                  o_ovf,
`endif
    output logic signed [2*W-1:0] o_sum
);

    logic signed [2*W-1:0] w_a_ext;
    logic signed [2*W-1:0] w_b_ext;
    logic signed [2*W-1:0] w_prod;

    // Widen first so the product is formed at full 2W precision.
    assign w_a_ext = {{W{i_a[W-1]}}, i_a};
    assign w_b_ext = {{W{i_b[W-1]}}, i_b};
    assign w_prod  = w_a_ext * w_b_ext;
    assign o_sum   = i_sub ? (i_acc - w_prod) : (i_acc + w_prod);

`ifdef MATDET_OVF_FLAG_EN
    // Overflow: operands effectively share a sign but the result flips it.
    assign o_ovf = (i_sub ? (i_acc[2*W-1] != w_prod[2*W-1]) : (i_acc[2*W-1] == w_prod[2*W-1]))
                   && (o_sum[2*W-1] != i_acc[2*W-1]);
`endif

endmodule

// File: rtl/matrix_det_sequencer.sv
// Sequential det(A*B) for 2x2 signed matrices using two time-shared MACs.
// Optional overflow flag output when MATDET_OVF_FLAG_EN is defined.
module matrix_det_sequencer
    import matdet_pkg::*;
#(
    parameter int WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*WIDTH-1:0]   matA,
    input  logic [4*WIDTH-1:0]   matB,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*WIDTH-1:0]   det_out,
`ifdef MATDET_OVF_FLAG_EN
    output logic                 ovf,
`endif
    output state_t               dbg_state
);

    localparam int CW = 2 * WIDTH;
    localparam int DW = 4 * WIDTH;

    // Handshake: a job moves on an edge where in_valid && in_ready; a result
    // leaves on an edge where out_valid && out_ready. Both flags are registered.
    state_t                r_state;
    logic [2:0]            r_step;
    logic [DW-1:0]         r_a;
    logic [DW-1:0]         r_b;
    logic signed [CW-1:0]  r_c [4];
    logic signed [DW-1:0]  r_det_acc;
    logic [DW-1:0]         r_det;
    logic                  r_out_valid;
    logic                  r_in_ready;

    logic [1:0]            w_a_idx;
    logic [1:0]            w_b_idx;
    logic [1:0]            w_c_idx;
    logic signed [WIDTH-1:0] w_mul_a;
    logic signed [WIDTH-1:0] w_mul_b;
    logic signed [CW-1:0]  w_mul_acc;
    logic signed [CW-1:0]  w_c_sum;
    logic signed [CW-1:0]  w_det_a;
    logic signed [CW-1:0]  w_det_b;
    logic signed [DW-1:0]  w_det_acc;
    logic signed [DW-1:0]  w_det_sum;

    function automatic logic signed [WIDTH-1:0] elem(input logic [DW-1:0] m, input logic [1:0] idx);
        return m[(3 - int'(idx))*WIDTH +: WIDTH];
    endfunction

    // Step bits map to operands: step[2]=row of A, step[1]=col of B, step[0]=inner index.
    assign w_a_idx   = {r_step[2], r_step[0]};
    assign w_b_idx   = {r_step[0], r_step[1]};
    assign w_c_idx   = r_step[2:1];
    assign w_mul_a   = elem(r_a, w_a_idx);
    assign w_mul_b   = elem(r_b, w_b_idx);
    assign w_mul_acc = r_step[0] ? r_c[w_c_idx] : '0;

    assign w_det_a   = r_step[0] ? r_c[1] : r_c[0];
    assign w_det_b   = r_step[0] ? r_c[2] : r_c[3];
    assign w_det_acc = r_step[0] ? r_det_acc : '0;

`ifdef MATDET_OVF_FLAG_EN
    logic r_ovf_acc;
    logic r_ovf;
    logic w_c_ovf;
    logic w_det_ovf;
    assign ovf = r_ovf;
`endif

    matdet_mac #(.W(WIDTH)) u_mac_c (
        .i_a   (w_mul_a),
        .i_b   (w_mul_b),
        .i_acc (w_mul_acc),
        .i_sub (1'b0),
`ifdef MATDET_OVF_FLAG_EN
        .o_ovf (w_c_ovf),
`endif
        .o_sum (w_c_sum)
    );

    matdet_mac #(.W(CW)) u_mac_det (
        .i_a   (w_det_a),
        .i_b   (w_det_b),
        .i_acc (w_det_acc),
        .i_sub (r_step[0]),
`ifdef MATDET_OVF_FLAG_EN
        .o_ovf (w_det_ovf),
`endif
        .o_sum (w_det_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            for (int i = 0; i < 4; i++) r_c[i] <= '0;
            r_det_acc   <= '0;
            r_det       <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef MATDET_OVF_FLAG_EN
            r_ovf_acc   <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else if (clr) begin
            r_state     <= IDLE;
            r_step      <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
`ifdef MATDET_OVF_FLAG_EN
            r_ovf_acc   <= 1'b0;
            r_ovf       <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_a        <= matA;
                        r_b        <= matB;
                        r_step     <= '0;
                        r_state    <= MUL;
                        r_in_ready <= 1'b0;
`ifdef MATDET_OVF_FLAG_EN
                        r_ovf_acc  <= 1'b0;
                        r_ovf      <= 1'b0;
`endif
                    end
                end
                MUL: begin
                    r_c[w_c_idx] <= w_c_sum;
`ifdef MATDET_OVF_FLAG_EN
                    r_ovf_acc    <= r_ovf_acc | w_c_ovf;
`endif
                    if (r_step == 3'(MUL_STEPS - 1)) begin
                        r_step  <= '0;
                        r_state <= DET;
                    end else begin
                        r_step  <= r_step + 3'd1;
                    end
                end
                DET: begin
                    if (r_step == 3'(DET_STEPS - 1)) begin
                        r_det       <= w_det_sum;
                        r_out_valid <= 1'b1;
                        r_step      <= '0;
                        r_state     <= DONE;
`ifdef MATDET_OVF_FLAG_EN
                        r_ovf       <= r_ovf_acc | w_det_ovf;
`endif
                    end else begin
                        r_det_acc <= w_det_sum;
                        r_step    <= r_step + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign det_out   = r_det;
    assign dbg_state = r_state;

endmodule

// File: doc/matrix_det_sequencer.md
MATRIX_DET_SEQUENCER -- requirements
Module: matrix_det_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 7, meaning signed bit-width of each matrix element.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port clr, input, 1 bit: synchronous abort to IDLE.
REQ-005 SHALL have port in_valid, input, 1 bit: matA/matB valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a job.
REQ-007 SHALL have port matA, input, 4*WIDTH bits: {a00,a01,a10,a11}, MSB-first.
REQ-008 SHALL have port matB, input, 4*WIDTH bits: {b00,b01,b10,b11}, MSB-first.
REQ-009 SHALL have port out_valid, output, 1 bit: det_out holds a finished result.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port det_out, output, 4*WIDTH bits: signed det(A*B).

Function
REQ-012 SHALL compute det(C), where C=A*B, using exactly one signed WIDTH x WIDTH multiplier and one signed 2W x 2W multiplier, time-shared at one product per cycle.
REQ-013 SHALL implement states IDLE, MUL, DET and DONE.
REQ-014 SHALL drive in_ready=1 only in IDLE, and SHALL register matA/matB on an edge with in_valid&&in_ready, then go to MUL with step=0.
REQ-015 SHALL, in MUL, accumulate one product per cycle over steps 0..7 in order a00*b00, a01*b10, a00*b01, a01*b11, a10*b00, a11*b10, a10*b01, a11*b11, and SHALL go to DET after step 7.
REQ-016 SHALL store each C element as 2*WIDTH bits signed, with two's-complement wrap on overflow.
REQ-017 SHALL, in DET, compute c00*c11 in cycle 0 and subtract c01*c10 in cycle 1, with 4*WIDTH-bit wrapping arithmetic, then register det_out and go to DONE.
REQ-018 SHALL assert out_valid exactly 10 rising edges after the accepting edge, only in DONE.
REQ-019 SHALL, in DONE, hold out_valid and det_out stable while out_ready=0, and SHALL return to IDLE on out_valid&&out_ready.
REQ-020 SHALL keep det_out at its last value after dequeue until the next result is registered.
REQ-021 SHALL make clr=1 return to IDLE from any state on the next edge, discard a partial job, drop out_valid, and leave det_out unchanged.
REQ-022 SHALL give clr priority over in_valid in IDLE (no accept) and over out_ready in DONE.

Reset
REQ-023 SHALL, on reset_n=0, immediately force IDLE, step=0, in_ready=1 after release, out_valid=0, det_out=0, and all C registers and operand registers to 0.
REQ-024 SHALL abort any job in progress when reset is asserted mid-operation, with no output produced.

Configuration
REQ-025 SHALL, with macro MATDET_OVF_FLAG_EN defined, add output ovf (1 bit, reset 0), set with det_out when any C element sum or the final subtraction overflowed its width, and cleared on the next accept or clr.
REQ-026 SHALL, without MATDET_OVF_FLAG_EN, have no ovf port and no overflow-detection logic.

Structure
REQ-027 SHALL place the state enum, MUL_STEPS=8 and DET_STEPS=2 in shared package matdet_pkg.
REQ-028 SHALL use one sub-module, matdet_mac (signed multiply-accumulate with a parameterized width), instantiated twice.

Verification
REQ-029 SHALL check: A={1,2,3,4}, B={5,6,7,8} -> out_valid 10 cycles after accept, det_out=4.
REQ-030 SHALL check: A={1,0,0,1}, B={-3,1,2,-5} -> det_out=13; then a back-to-back second job is accepted on the cycle after dequeue.
REQ-031 SHALL check: out_ready held 0 for 5 cycles in DONE -> out_valid=1 and det_out constant throughout; in_ready=0 throughout.
REQ-032 SHALL check: A={-64,-64,0,0}, B={-64,-64,-64,-64} -> c00 wraps to -8192; with MATDET_OVF_FLAG_EN, ovf=1.
REQ-033 SHALL check: clr pulsed at MUL step 4 -> IDLE next edge, no out_valid, det_out retains the previous result.
REQ-034 SHALL check: reset_n asserted during DET -> out_valid=0 and det_out=0 immediately; after release, in_ready=1.
